// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master (instruction/data) to single-memory-bus arbiter,
//               one outstanding transaction, data-priority with starvation cap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // instruction side
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_cancel,
  output logic                i_allow,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_allow,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_owner_d;
  logic                r_we;
  logic [c_STRB_W-1:0] r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_CNT_W-1:0]  r_starve;
  logic                r_drop;

  logic                w_idle;
  logic                w_force_i;
  logic                w_grant_d;
  logic                w_grant_i;

  // Grants are masked during reset so nothing is offered that cannot be latched.
  assign w_idle    = (r_state == S_IDLE) && !reset;
  assign w_force_i = i_req && (r_starve == c_STARVE_MAX);
  assign w_grant_d = w_idle && d_req && !w_force_i;
  assign w_grant_i = w_idle && i_req && !w_grant_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_grant_d || w_grant_i) w_state_nxt = S_ADDR;
      S_ADDR: if (m_addr_ok)              w_state_nxt = S_RESP;
      S_RESP: if (m_data_ok)              w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction transactions latch zeroed write fields so the bus never sees
  // stale data-side values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_wstrb   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_owner_d <= w_grant_d;
      r_we      <= w_grant_d && d_we;
      r_wstrb   <= w_grant_d ? d_wstrb : '0;
      r_addr    <= w_grant_d ? d_addr  : i_addr;
      r_wdata   <= w_grant_d ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE) begin
      if (!i_req || w_grant_i) begin
        r_starve <= '0;
      end else if (w_grant_d && (r_starve != c_STARVE_MAX)) begin
        r_starve <= r_starve + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= 1'b0;
    end else if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) begin
      r_drop <= 1'b0;
    end else if (i_cancel && !r_owner_d) begin
      r_drop <= 1'b1;
    end
  end

  // A cancel arriving together with m_data_ok must still suppress the response.
  always_comb begin
    i_allow  = w_grant_i;
    d_allow  = w_grant_d;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_wstrb  = '0;
    m_addr   = '0;
    m_wdata  = '0;
    busy     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_ADDR: begin
          busy    = 1'b1;
          m_req   = 1'b1;
          m_we    = r_we;
          m_wstrb = r_wstrb;
          m_addr  = r_addr;
          m_wdata = r_wdata;
        end
        S_RESP: begin
          busy = 1'b1;
          if (m_data_ok) begin
            if (r_owner_d) begin
              d_rvalid = 1'b1;
              d_rdata  = m_rdata;
            end else if (!r_drop && !i_cancel) begin
              i_rvalid = 1'b1;
              i_rdata  = m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              i_req, i_cancel, i_allow, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_allow, d_rvalid;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              m_req, m_we, m_addr_ok, m_data_ok, busy;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_allow(i_allow),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_allow(d_allow), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: one in-flight record plus a data-win counter.
  bit              md_busy, md_acc, md_own_d, md_drop, md_we;
  logic [3:0]      md_wstrb;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_wdata;
  int              md_wins;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    bit              e_ia, e_da, e_iv, e_dv, e_mr, e_mw, e_busy;
    logic [3:0]      e_ws;
    logic [ADDR_W-1:0] e_ma;
    logic [DATA_W-1:0] e_wd, e_ir, e_dr;
    #4;
    {e_ia, e_da, e_iv, e_dv, e_mr, e_mw, e_busy} = '0;
    e_ws = '0; e_ma = '0; e_wd = '0; e_ir = '0; e_dr = '0;
    if (!reset) begin
      if (!md_busy) begin
        if (d_req && !(i_req && md_wins == STARVE_MAX)) e_da = 1'b1;
        else if (i_req) e_ia = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (!md_acc) begin
          e_mr = 1'b1; e_mw = md_we; e_ws = md_wstrb; e_ma = md_addr; e_wd = md_wdata;
        end else if (m_data_ok) begin
          if (md_own_d) begin
            e_dv = 1'b1; e_dr = m_rdata;
          end else if (!md_drop && !i_cancel) begin
            e_iv = 1'b1; e_ir = m_rdata;
          end
        end
      end
    end
    chk("i_allow",  64'(i_allow),  64'(e_ia));
    chk("d_allow",  64'(d_allow),  64'(e_da));
    chk("i_rvalid", 64'(i_rvalid), 64'(e_iv));
    chk("i_rdata",  64'(i_rdata),  64'(e_ir));
    chk("d_rvalid", 64'(d_rvalid), 64'(e_dv));
    chk("d_rdata",  64'(d_rdata),  64'(e_dr));
    chk("m_req",    64'(m_req),    64'(e_mr));
    chk("m_we",     64'(m_we),     64'(e_mw));
    chk("m_wstrb",  64'(m_wstrb),  64'(e_ws));
    chk("m_addr",   64'(m_addr),   64'(e_ma));
    chk("m_wdata",  64'(m_wdata),  64'(e_wd));
    chk("busy",     64'(busy),     64'(e_busy));
  endtask

  task automatic model_step();
    bit gd, gi;
    if (reset) begin
      md_busy = 0; md_acc = 0; md_drop = 0; md_own_d = 0; md_wins = 0;
    end else if (!md_busy) begin
      gd = d_req && !(i_req && md_wins == STARVE_MAX);
      gi = i_req && !gd;
      if (gd || gi) begin
        md_busy = 1; md_acc = 0; md_drop = 0; md_own_d = gd;
        md_we    = gd && d_we;
        md_wstrb = gd ? d_wstrb : 4'h0;
        md_addr  = gd ? d_addr : i_addr;
        md_wdata = gd ? d_wdata : '0;
      end
      if (gi || !i_req) md_wins = 0;
      else if (gd) md_wins = (md_wins < STARVE_MAX) ? md_wins + 1 : STARVE_MAX;
    end else begin
      if (i_cancel && !md_own_d) md_drop = 1;
      if (!md_acc) begin
        if (m_addr_ok) md_acc = 1;
      end else if (m_data_ok) begin
        md_busy = 0; md_drop = 0;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; i_cancel = 0;
    d_req = 0; d_we = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  initial begin
    int g;
    clear_inputs();
    reset = 1;
    md_busy = 0; md_acc = 0; md_drop = 0; md_own_d = 0; md_wins = 0;
    md_we = 0; md_wstrb = '0; md_addr = '0; md_wdata = '0;
    settle(); advance();
    settle();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_mreq", 64'(m_req), 64'(0));
    advance();
    reset = 0;

    // single instruction read
    i_req = 1; i_addr = 32'h1000;
    settle(); chk("r22_allow", 64'(i_allow), 64'(1)); advance();
    i_req = 0; m_addr_ok = 1;
    settle(); chk("r22_mreq", 64'(m_req), 64'(1)); chk("r22_maddr", 64'(m_addr), 64'h1000); advance();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    settle(); chk("r22_rvalid", 64'(i_rvalid), 64'(1)); chk("r22_rdata", 64'(i_rdata), 64'hDEADBEEF); advance();
    m_data_ok = 0;
    settle(); chk("r22_idle", 64'(busy), 64'(0)); advance();

    // continuous contention: four data wins, then one forced instruction win
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; m_addr_ok = 1; m_data_ok = 1;
    g = 0;
    for (int c = 0; c < 45; c++) begin
      settle();
      if (i_allow || d_allow) begin
        chk("r23_grant_is_i", 64'(i_allow), 64'((g % 5) == 4));
        g++;
      end
      advance();
    end
    chk("r23_grant_count", 64'(g), 64'(15));
    clear_inputs();

    // write held in address phase
    d_req = 1; d_we = 1; d_wstrb = 4'hF; d_addr = 32'h2000; d_wdata = 32'h12345678;
    settle(); chk("r24_allow", 64'(d_allow), 64'(1)); advance();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      m_addr_ok = (c == 3);
      settle();
      chk("r24_mreq", 64'(m_req), 64'(1));
      chk("r24_wdata", 64'(m_wdata), 64'h12345678);
      chk("r24_addr", 64'(m_addr), 64'h2000);
      advance();
    end
    m_addr_ok = 0; m_data_ok = 1;
    settle(); chk("r24_ack", 64'(d_rvalid), 64'(1)); advance();
    clear_inputs();

    // cancelled instruction read, followed by a normal data read
    i_req = 1; i_addr = 32'h3000;
    settle(); advance();
    i_req = 0; m_addr_ok = 1;
    settle(); advance();
    m_addr_ok = 0; i_cancel = 1;
    settle(); advance();
    i_cancel = 0; m_data_ok = 1; m_rdata = 32'hAAAA5555;
    settle(); chk("r25_no_rvalid", 64'(i_rvalid), 64'(0)); chk("r25_busy", 64'(busy), 64'(1)); advance();
    m_data_ok = 0; d_req = 1; d_addr = 32'h4000;
    settle(); chk("r25_d_allow", 64'(d_allow), 64'(1)); advance();
    d_req = 0; m_addr_ok = 1;
    settle(); chk("r25_maddr", 64'(m_addr), 64'h4000); advance();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0BADF00D;
    settle(); chk("r25_d_rdata", 64'(d_rdata), 64'h0BADF00D); advance();
    clear_inputs();

    // reset during response phase
    i_req = 1; i_addr = 32'h5000;
    settle(); advance();
    i_req = 0; m_addr_ok = 1;
    settle(); advance();
    m_addr_ok = 0; reset = 1;
    settle(); chk("r26_in_reset_busy", 64'(busy), 64'(0)); advance();
    reset = 0; m_data_ok = 1; m_rdata = 32'h11112222;
    settle();
    chk("r26_busy", 64'(busy), 64'(0));
    chk("r26_rvalid", 64'(i_rvalid), 64'(0));
    chk("r26_mreq", 64'(m_req), 64'(0));
    advance();
    clear_inputs();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      i_req     = $urandom_range(0, 1) == 1;
      i_addr    = $urandom;
      i_cancel  = ($urandom_range(0, 9) == 0);
      d_req     = $urandom_range(0, 1) == 1;
      d_we      = $urandom_range(0, 1) == 1;
      d_wstrb   = 4'($urandom);
      d_addr    = $urandom;
      d_wdata   = $urandom;
      m_addr_ok = $urandom_range(0, 1) == 1;
      m_data_ok = $urandom_range(0, 1) == 1;
      m_rdata   = $urandom;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, sets the data width; the strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, is the number of consecutive data wins after which a pending instruction request is forced through.
REQ-004 Clock clk; reset reset, synchronous, active-high.
REQ-005 Instruction-side ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  fetch address
- i_cancel  in  1  discard outstanding instruction response (flush)
- i_allow  out  1  instruction request accepted this cycle
- i_rvalid  out  1  instruction read data valid
- i_rdata  out  DATA_W  instruction read data
REQ-006 Data-side ports SHALL be:
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read
- d_wstrb  in  DATA_W/8  byte strobes
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_allow  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (read data or write ack)
- d_rdata  out  DATA_W  data read data
REQ-007 Memory-side ports SHALL be:
- m_req  out  1  bus request
- m_we  out  1  write
- m_wstrb  out  DATA_W/8  strobes
- m_addr  out  ADDR_W  address
- m_wdata  out  DATA_W  write data
- m_addr_ok  in  1  address accepted
- m_data_ok  in  1  response complete
- m_rdata  in  DATA_W  read data
- busy  out  1  transaction outstanding

Function
REQ-008 The FSM SHALL have three states, IDLE, ADDR and RESP, and SHALL keep at most one transaction outstanding.
REQ-009 In IDLE with any request pending, the arbiter SHALL combinationally assert exactly one of i_allow/d_allow, latch the winner's fields and owner, and move to ADDR next cycle.
REQ-010 The data side SHALL win a tie unless starve_cnt == STARVE_MAX, in which case the instruction side wins.
REQ-011 starve_cnt handling:
- +1 (saturating at STARVE_MAX) when data wins while i_req=1.
- Cleared when the instruction side wins, or in IDLE when i_req=0.
REQ-012 In ADDR, m_req=1 with the latched fields; on m_addr_ok=1 the FSM SHALL go to RESP; otherwise the request and fields SHALL be held stable.
REQ-013 In RESP, m_req=0; on m_data_ok=1 the FSM SHALL go to IDLE.
REQ-014 The owner's rvalid SHALL equal (state==RESP && m_data_ok) for one cycle, with rdata = m_rdata passed through combinationally; a write returns d_rvalid as an ack.
REQ-015 Outside REQ-014, i_rvalid/d_rvalid SHALL be 0 and i_rdata/d_rdata SHALL be 0.
REQ-016 i_allow/d_allow SHALL be 0 outside IDLE, so the minimum transaction is 3 cycles (IDLE, ADDR, RESP with immediate oks) with a one-cycle IDLE bubble between transactions.
REQ-017 m_we, m_wstrb and m_wdata SHALL be 0 for instruction transactions.
REQ-018 i_cancel=1 while an instruction transaction is in ADDR or RESP SHALL set a drop flag:
- Suppresses i_rvalid for that transaction, including when i_cancel coincides with m_data_ok.
- The bus transaction still completes.
- The flag clears on return to IDLE.
REQ-019 i_cancel SHALL have no effect in IDLE or on data transactions.
REQ-020 busy SHALL be 1 in ADDR and RESP, else 0.

Reset
REQ-021 Reset SHALL force IDLE, starve_cnt=0, drop flag=0 and all outputs 0, including mid-transaction; a subsequent m_data_ok for the abandoned transaction SHALL be ignored in IDLE.

Verification
REQ-022 i_req alone, addr 0x1000, m_addr_ok and m_data_ok each 1 cycle later, m_rdata=0xDEADBEEF -> i_allow at cycle 0, m_req at cycle 1, i_rvalid=1 with i_rdata=0xDEADBEEF at cycle 2.
REQ-023 i_req and d_req held continuously with immediate oks -> data granted 4 times, then 1 instruction grant; the pattern repeats.
REQ-024 Data write of 0x12345678 with wstrb 0xF, m_addr_ok delayed 3 cycles -> m_req and fields held stable for 4 cycles; d_rvalid=1 on m_data_ok.
REQ-025 Instruction read with i_cancel pulsed during RESP -> no i_rvalid; FSM returns to IDLE; the next d_req is granted normally.
REQ-026 Reset asserted in RESP -> next cycle all outputs 0 and IDLE; a late m_data_ok produces no rvalid.
